// File: rtl/gpio_axi_pkg.sv
// gpio_axi_pkg: shared definitions for the AXI4-Lite GPIO controller.
//   - register offsets (addr[7:0])
//   - AXI response codes
//   - maximum pin count
//   - helpers: byte-strobe expansion, address legality per access type
package gpio_axi_pkg;

  localparam int unsigned GPIO_MAX_WIDTH = 32;

  localparam logic [7:0] ADDR_OE       = 8'h00;
  localparam logic [7:0] ADDR_OUT      = 8'h04;
  localparam logic [7:0] ADDR_IN       = 8'h08;
  localparam logic [7:0] ADDR_OUT_SET  = 8'h0C;
  localparam logic [7:0] ADDR_OUT_CLR  = 8'h10;
  localparam logic [7:0] ADDR_OUT_TGL  = 8'h14;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h18;
  localparam logic [7:0] ADDR_IRQ_RISE = 8'h1C;
  localparam logic [7:0] ADDR_IRQ_FALL = 8'h20;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h24;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Expand WSTRB into a 32-bit bit-enable mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

  // IN is readable but not writable; every other mapped offset accepts both
  // (write-only registers read back as 0, IRQ registers are OKAY even when
  // the interrupt logic is compiled out).
  function automatic logic addr_ok(input logic [7:0] a, input logic is_wr);
    case (a)
      ADDR_IN: return !is_wr;
      ADDR_OE, ADDR_OUT, ADDR_OUT_SET, ADDR_OUT_CLR, ADDR_OUT_TGL,
      ADDR_IRQ_EN, ADDR_IRQ_RISE, ADDR_IRQ_FALL, ADDR_IRQ_STAT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpio_axi_lite_sync_edge.sv
// gpio_sync_edge: STAGES-deep synchroniser for a vector of asynchronous pad
// inputs, plus a previous-sample register for edge detection.
// Ports:
//   i_clk, i_rstn     clock, synchronous active-low reset
//   i_d   [WIDTH]     asynchronous inputs
//   o_s   [WIDTH]     synchronised value (last stage)
//   o_rise/o_fall     s & ~p / ~s & p, combinational from registered state
module gpio_sync_edge
  import gpio_axi_pkg::*;
#(
  parameter int unsigned WIDTH  = GPIO_MAX_WIDTH,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int unsigned k = 0; k < STAGES; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_s    = r_sync[STAGES-1];
  assign o_rise = o_s & ~r_prev;
  assign o_fall = ~o_s & r_prev;

endmodule

// File: rtl/gpio_axi_lite.sv
// gpio_axi_lite: AXI4-Lite GPIO controller with OE/OUT registers, atomic
// set/clear/toggle, synchronised input sampling and optional per-pin edge
// interrupts (sticky W1C status).
// Optional feature macro: GPIO_IRQ_EN (edge detect, IRQ_EN/RISE/FALL/STAT,
// irq output, post-reset settle counter). Undefined: those registers read 0,
// writes are OKAY no-ops, irq tied 0.
// Ports:
//   axi_aclk, axi_arstn            clock, synchronous active-low reset
//   M_AXI_AW*/W*/B*                write address/data/response channels
//   M_AXI_AR*/R*                   read address/data channels
//   gpio_i / gpio_o / gpio_oe      pad input, output value, output enable
//   irq                            registered level interrupt
module gpio_axi_lite
  import gpio_axi_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  axi_aclk,
  input  logic                  axi_arstn,
  input  logic                  M_AXI_AWVALID,
  output logic                  M_AXI_AWREADY,
  input  logic [31:0]           M_AXI_AWADDR,
  input  logic                  M_AXI_WVALID,
  output logic                  M_AXI_WREADY,
  input  logic [31:0]           M_AXI_WDATA,
  input  logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_BVALID,
  input  logic                  M_AXI_BREADY,
  output logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_ARVALID,
  output logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_ARADDR,
  output logic                  M_AXI_RVALID,
  input  logic                  M_AXI_RREADY,
  output logic [31:0]           M_AXI_RDATA,
  output logic [1:0]            M_AXI_RRESP,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] r_oe, r_out;
  logic [GPIO_WIDTH-1:0] w_in, w_rise, w_fall;
  logic                  r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [31:0]           r_rdata, w_rdata;

  gpio_sync_edge #(.WIDTH(GPIO_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (axi_aclk),
    .i_rstn (axi_arstn),
    .i_d    (gpio_i),
    .o_s    (w_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  logic [7:0]            w_waddr, w_raddr;
  logic                  w_wr_fire, w_rd_fire;
  logic [31:0]           w_strb32, w_bits32;
  logic [GPIO_WIDTH-1:0] w_bits, w_keep;

  assign w_waddr   = M_AXI_AWADDR[7:0];
  assign w_raddr   = M_AXI_ARADDR[7:0];
  assign w_wr_fire = r_awready & M_AXI_AWVALID & M_AXI_WVALID;
  assign w_rd_fire = r_arready & M_AXI_ARVALID;
  assign w_strb32  = strb_to_mask(M_AXI_WSTRB);
  assign w_bits32  = M_AXI_WDATA & w_strb32;
  // w_bits: strobed data bits; w_keep: bits whose byte lane is not strobed.
  assign w_bits    = w_bits32[GPIO_WIDTH-1:0];
  assign w_keep    = ~w_strb32[GPIO_WIDTH-1:0];

  logic w_unused_addr;
  assign w_unused_addr = ^{M_AXI_AWADDR[31:8], M_AXI_ARADDR[31:8]};

  // Channel handshakes: READY pulses are registered, so a request is accepted
  // on the second cycle it is presented; the pending response blocks reissue.
  always_ff @(posedge axi_aclk) begin
    if (!axi_arstn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_awready <= M_AXI_AWVALID & M_AXI_WVALID & ~r_bvalid & ~r_awready;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= addr_ok(w_waddr, 1'b1) ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && M_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= M_AXI_ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= addr_ok(w_raddr, 1'b0) ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && M_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_arstn) begin
      r_oe  <= '0;
      r_out <= '0;
    end else if (w_wr_fire) begin
      case (w_waddr)
        ADDR_OE:      r_oe  <= (r_oe & w_keep) | w_bits;
        ADDR_OUT:     r_out <= (r_out & w_keep) | w_bits;
        ADDR_OUT_SET: r_out <= r_out | w_bits;
        ADDR_OUT_CLR: r_out <= r_out & ~w_bits;
        ADDR_OUT_TGL: r_out <= r_out ^ w_bits;
        default: ;
      endcase
    end
  end

`ifdef GPIO_IRQ_EN
  localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

  logic [GPIO_WIDTH-1:0] r_irq_en, r_irq_rise, r_irq_fall, r_irq_stat;
  logic [GPIO_WIDTH-1:0] w_edges, w_stat_clr;
  logic [2:0]            r_settle;
  logic                  r_irq, w_settled;

  // The synchroniser starts from 0, so a pin already high at reset release
  // looks like a rising edge until the chain and previous sample have filled.
  assign w_settled  = (r_settle == SETTLE_CYCLES);
  assign w_edges    = w_settled ? ((w_rise & r_irq_rise) | (w_fall & r_irq_fall)) : '0;
  assign w_stat_clr = (w_wr_fire && w_waddr == ADDR_IRQ_STAT) ? w_bits : '0;

  always_ff @(posedge axi_aclk) begin
    if (!axi_arstn) begin
      r_settle   <= '0;
      r_irq_en   <= '0;
      r_irq_rise <= '0;
      r_irq_fall <= '0;
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (!w_settled) r_settle <= r_settle + 3'd1;
      if (w_wr_fire) begin
        case (w_waddr)
          ADDR_IRQ_EN:   r_irq_en   <= (r_irq_en & w_keep) | w_bits;
          ADDR_IRQ_RISE: r_irq_rise <= (r_irq_rise & w_keep) | w_bits;
          ADDR_IRQ_FALL: r_irq_fall <= (r_irq_fall & w_keep) | w_bits;
          default: ;
        endcase
      end
      // Clear applied before set so a same-cycle new edge wins.
      r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_edges;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_edges;
  assign w_unused_edges = ^{w_rise, w_fall};
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      ADDR_OE:       w_rdata = 32'(r_oe);
      ADDR_OUT:      w_rdata = 32'(r_out);
      ADDR_IN:       w_rdata = 32'(w_in);
`ifdef GPIO_IRQ_EN
      ADDR_IRQ_EN:   w_rdata = 32'(r_irq_en);
      ADDR_IRQ_RISE: w_rdata = 32'(r_irq_rise);
      ADDR_IRQ_FALL: w_rdata = 32'(r_irq_fall);
      ADDR_IRQ_STAT: w_rdata = 32'(r_irq_stat);
`endif
      default: ;
    endcase
  end

  assign M_AXI_AWREADY = r_awready;
  assign M_AXI_WREADY  = r_awready;
  assign M_AXI_BVALID  = r_bvalid;
  assign M_AXI_BRESP   = r_bresp;
  assign M_AXI_ARREADY = r_arready;
  assign M_AXI_RVALID  = r_rvalid;
  assign M_AXI_RDATA   = r_rdata;
  assign M_AXI_RRESP   = r_rresp;
  assign gpio_o        = r_out;
  assign gpio_oe       = r_oe;

endmodule

// File: tb/tb_gpio_axi_lite.sv
// tb_gpio_axi_lite: directed self-checking bench for gpio_axi_lite.
// Interrupt scenarios are exercised when GPIO_IRQ_EN is defined; otherwise
// the bench checks that the interrupt registers are inert.
module tb_gpio_axi_lite;
  localparam int unsigned W  = 32;
  localparam int unsigned SS = 2;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [W-1:0]  gpio_i = '0, gpio_o, gpio_oe;

  int n_checks = 0;
  int n_errors = 0;

  gpio_axi_lite #(.GPIO_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .axi_aclk(clk), .axi_arstn(rstn),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_BRESP(bresp), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_ARADDR(araddr), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered and left on a negedge; VALIDs held until READY observed.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] exp_resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check($sformatf("awready@%h", a[7:0]), 32'(awready & wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check($sformatf("bvalid@%h", a[7:0]), 32'(bvalid), 32'd1);
    check($sformatf("bresp@%h", a[7:0]), 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check($sformatf("arready@%h", a[7:0]), 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check($sformatf("rvalid@%h", a[7:0]), 32'(rvalid), 32'd1);
    check($sformatf("rdata@%h", a[7:0]), rdata, exp_data);
    check($sformatf("rresp@%h", a[7:0]), 32'(rresp), 32'(exp_resp));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    cycles(3);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_gpio_o", gpio_o, '0);
    check("rst_gpio_oe", gpio_oe, '0);
    check("rst_irq", 32'(irq), 0);
    check("rst_ready", 32'({awready, wready, arready}), 0);
    check("rst_valid", 32'({bvalid, rvalid}), 0);
    check("rst_rdata", rdata, '0);
    check("rst_resp", 32'({bresp, rresp}), 0);
    for (int i = 0; i < 10; i++) rd(32'(i * 4), 32'h0, OKAY);

    // Direction/output and atomic ops: F0 |1 =F1, &~10 =E1, ^3 =E2
    wr(32'h00, 32'hFFFF_FFFF, 4'hF, OKAY);
    wr(32'h04, 32'h0000_00F0, 4'hF, OKAY);
    wr(32'h0C, 32'h0000_0001, 4'hF, OKAY);
    wr(32'h10, 32'h0000_0010, 4'hF, OKAY);
    wr(32'h14, 32'h0000_0003, 4'hF, OKAY);
    check("gpio_o_atomic", gpio_o, 32'h0000_00E2);
    check("gpio_oe_all", gpio_oe, 32'hFFFF_FFFF);
    rd(32'h04, 32'h0000_00E2, OKAY);
    rd(32'h00, 32'hFFFF_FFFF, OKAY);
    rd(32'h0C, 32'h0, OKAY);

    // Byte strobes
    wr(32'h04, 32'hAABB_CCDD, 4'b0101, OKAY);
    check("gpio_o_strb", gpio_o, 32'h00BB_00DD);
    rd(32'h04, 32'h00BB_00DD, OKAY);
    wr(32'h0C, 32'hFFFF_FFFF, 4'b0010, OKAY);
    check("gpio_o_set_strb", gpio_o, 32'h00BB_FFDD);
    wr(32'h00, 32'h0000_0000, 4'b1000, OKAY);
    check("gpio_oe_strb", gpio_oe, 32'h00FF_FFFF);

    // Error responses, IN unaffected
    gpio_i = 32'h0000_A5A5;
    cycles(SS + 2);
    rd(32'h08, 32'h0000_A5A5, OKAY);
    rd(32'h80, 32'h0, SLVERR);
    wr(32'h08, 32'hFFFF_FFFF, 4'hF, SLVERR);
    wr(32'h28, 32'hFFFF_FFFF, 4'hF, SLVERR);
    rd(32'h08, 32'h0000_A5A5, OKAY);
    check("gpio_o_after_err", gpio_o, 32'h00BB_FFDD);
    gpio_i = '0;
    cycles(SS + 2);

    // BREADY stalled: BVALID held, no second acceptance of the held toggle
    awaddr = 32'h14; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("stall_awready", 32'(awready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_bvalid%0d", i), 32'(bvalid), 1);
      check($sformatf("stall_noaw%0d", i), 32'(awready), 0);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("stall_bvalid_done", 32'(bvalid), 0);
    check("stall_single_tgl", gpio_o, 32'h00BB_FFDC);

`ifdef GPIO_IRQ_EN
    // Rising edge interrupt latency
    wr(32'h1C, 32'h1, 4'hF, OKAY);
    wr(32'h18, 32'h1, 4'hF, OKAY);
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= int'(SS) + 2; k++) begin
      @(negedge clk);
      if (k == int'(SS) + 1) check("irq_not_yet", 32'(irq), 0);
      if (k == int'(SS) + 2) check("irq_rise", 32'(irq), 1);
    end
    rd(32'h24, 32'h1, OKAY);
    rd(32'h08, 32'h1, OKAY);
    wr(32'h24, 32'h1, 4'hF, OKAY);
    check("irq_cleared", 32'(irq), 0);
    rd(32'h24, 32'h0, OKAY);

    // Falling edge only where enabled
    gpio_i[0] = 1'b0;
    cycles(6);
    rd(32'h24, 32'h0, OKAY);
    wr(32'h20, 32'h2, 4'hF, OKAY);
    gpio_i[1] = 1'b1;
    cycles(6);
    rd(32'h24, 32'h0, OKAY);
    gpio_i[1] = 1'b0;
    cycles(6);
    rd(32'h24, 32'h2, OKAY);
    check("irq_masked", 32'(irq), 0);
    wr(32'h24, 32'h2, 4'hF, OKAY);

    // Pending bit0, then W1C colliding with a fresh rising edge
    gpio_i[0] = 1'b1;
    cycles(6);
    gpio_i[0] = 1'b0;
    cycles(6);
    check("irq_pending", 32'(irq), 1);
    gpio_i[0] = 1'b1;
    cycles(int'(SS) - 1);
    wr(32'h24, 32'h1, 4'hF, OKAY);
    check("irq_set_wins", 32'(irq), 1);
    rd(32'h24, 32'h1, OKAY);
    wr(32'h24, 32'h1, 4'b1110, OKAY);
    rd(32'h24, 32'h1, OKAY);
    wr(32'h24, 32'h1, 4'b0001, OKAY);
    rd(32'h24, 32'h0, OKAY);
    check("irq_final_clear", 32'(irq), 0);
`else
    wr(32'h18, 32'h1, 4'hF, OKAY);
    wr(32'h1C, 32'h1, 4'hF, OKAY);
    rd(32'h18, 32'h0, OKAY);
    gpio_i[0] = 1'b1;
    cycles(6);
    check("irq_tied", 32'(irq), 0);
    rd(32'h24, 32'h0, OKAY);
    rd(32'h08, 32'h1, OKAY);
`endif

    // Reset during a pending write response
    awaddr = 32'h04; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("mid_bvalid", 32'(bvalid), 1);
    awvalid = 1'b0; wvalid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_bvalid", 32'(bvalid), 0);
    check("mid_rst_gpio_o", gpio_o, '0);

`ifdef GPIO_IRQ_EN
    // Pins high through reset must not register as rising edges
    gpio_i = '1;
    cycles(2);
    rstn = 1'b1;
    wr(32'h1C, 32'hFFFF_FFFF, 4'hF, OKAY);
    cycles(4);
    rd(32'h24, 32'h0, OKAY);
    rd(32'h08, 32'hFFFF_FFFF, OKAY);
    gpio_i[0] = 1'b0;
    cycles(6);
    gpio_i[0] = 1'b1;
    cycles(6);
    rd(32'h24, 32'h1, OKAY);
`else
    cycles(2);
    rstn = 1'b1;
    @(negedge clk);
    rd(32'h04, 32'h0, OKAY);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
